// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounced SR-latch driver.
package debounce_pkg;

    // Two idle states hold a settled level; two wait states time a candidate edge.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    // Consecutive synchronized samples needed before a new level is accepted.
    localparam int DEFAULT_P_STABLE = 4;

    // Flop depth of the metastability synchronizer.
    localparam int DEFAULT_P_SYNC = 2;

endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchronizer for one asynchronous bit; no logic between stages.
module sync_chain #(
    parameter int p_sync = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [p_sync-1:0] stages;

    // Shift the raw bit through the chain; stage 0 is the only one that can go metastable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[p_sync-2:0], d};
        end
    end

    assign q = stages[p_sync-1];

endmodule

// File: rtl/debounce_sr_driver.sv
// Synchronizes and debounces a raw input, emitting one-cycle set/reset pulses
// for a downstream SR latch plus the debounced level that latch will hold.
module debounce_sr_driver
    import debounce_pkg::*;
#(
    parameter int p_stable = DEFAULT_P_STABLE,
    parameter int p_sync   = DEFAULT_P_SYNC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic s,
    output logic r,
    output logic level,
    output logic busy
);

    // The counter only ever reaches p_stable-1, so this width never wraps.
    localparam int cnt_w = $clog2(p_stable + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(p_stable - 1);
    localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

    logic             sync;
    state_t           state;
    state_t           state_next;
    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] cnt_next;
    logic             s_next;
    logic             r_next;
    logic             level_next;

    sync_chain #(
        .p_sync (p_sync)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (raw_in),
        .q       (sync)
    );

    // State, counter and all pulse/level outputs are registered together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
            s     <= 1'b0;
            r     <= 1'b0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            s     <= s_next;
            r     <= r_next;
            level <= level_next;
        end
    end

    // Next-state logic: a candidate edge must survive p_stable samples or it is dropped.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        s_next     = 1'b0;
        r_next     = 1'b0;
        level_next = level;
        case (state)
            IDLE_LO: begin
                if (sync) begin
                    if (p_stable == 1) begin
                        state_next = IDLE_HI;
                        s_next     = 1'b1;
                        level_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT_HI;
                        cnt_next   = cnt_one;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_HI: begin
                if (sync) begin
                    if (cnt == cnt_last) begin
                        state_next = IDLE_HI;
                        s_next     = 1'b1;
                        level_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + cnt_one;
                    end
                end else begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end
            end
            IDLE_HI: begin
                if (!sync) begin
                    if (p_stable == 1) begin
                        state_next = IDLE_LO;
                        r_next     = 1'b1;
                        level_next = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT_LO;
                        cnt_next   = cnt_one;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_LO: begin
                if (!sync) begin
                    if (cnt == cnt_last) begin
                        state_next = IDLE_LO;
                        r_next     = 1'b1;
                        level_next = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + cnt_one;
                    end
                end else begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

    assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_debounce_sr_driver.sv
// Self-checking bench: expected pulses (kind and cycle) are queued when stimulus
// is driven and matched against what the DUT emits; a second p_stable=1 instance
// drives a behavioural SR latch whose output must track the debounced level.
module tb_debounce_sr_driver;

    localparam int p_stable = 4;
    localparam int p_sync   = 2;
    localparam int lat      = p_sync + p_stable;

    typedef struct {
        int kind;
        int cyc;
    } pulse_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic raw_in  = 1'b1;
    logic s, r, level, busy;

    logic raw_in1 = 1'b0;
    logic s1, r1, level1, busy1;
    logic q1 = 1'b0;

    int     cyc       = 0;
    int     n_checks  = 0;
    int     n_fails   = 0;
    pulse_t exp_q[$];

    debounce_sr_driver #(
        .p_stable (p_stable),
        .p_sync   (p_sync)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_in  (raw_in),
        .s       (s),
        .r       (r),
        .level   (level),
        .busy    (busy)
    );

    debounce_sr_driver #(
        .p_stable (1),
        .p_sync   (2)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_in  (raw_in1),
        .s       (s1),
        .r       (r1),
        .level   (level1),
        .busy    (busy1)
    );

    always #5 clk = ~clk;

    // Cycle index used to timestamp expected and observed pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural level-sensitive SR latch fed by the second instance.
    always @(s1 or r1 or reset_n) begin
        if (!reset_n)  q1 = 1'b0;
        else if (s1)   q1 = 1'b1;
        else if (r1)   q1 = 1'b0;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Drive raw_in at a falling edge, optionally queue the pulse it must produce, then dwell.
    task automatic applyStimulus(input logic value, input int dwell, input int expect_kind);
        pulse_t e;
        raw_in = value;
        if (expect_kind != 0) begin
            e.kind = expect_kind;
            e.cyc  = cyc + lat;
            exp_q.push_back(e);
        end
        repeat (dwell) @(negedge clk);
    endtask

    // Wait a bounded number of cycles for all queued pulses to be observed.
    task automatic waitPulses(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("pulse_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Scoreboard: every observed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        pulse_t e;
        if (s || r) begin
            checkOutput("s_r_exclusive", int'(s & r), 0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", s ? 1 : 2, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_kind", s ? 1 : 2, e.kind);
                checkOutput("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with raw_in high: everything stays quiet.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_s", s, 0);
            checkOutput("reset_r", r, 0);
            checkOutput("reset_level", level, 0);
            checkOutput("reset_busy", busy, 0);
        end
        reset_n = 1'b1;
        applyStimulus(1'b1, 1, 1);
        waitPulses(12);
        checkOutput("post_reset_level", level, 1);

        // Clean fall, rise, fall.
        applyStimulus(1'b0, 1, 2);
        waitPulses(12);
        checkOutput("fall_level", level, 0);
        applyStimulus(1'b1, 1, 1);
        waitPulses(12);
        checkOutput("rise_level", level, 1);
        applyStimulus(1'b0, 1, 2);
        waitPulses(12);
        checkOutput("fall2_level", level, 0);

        // Glitch shorter than the stability window is rejected.
        applyStimulus(1'b1, 3, 0);
        checkOutput("glitch_busy_high", busy, 1);
        applyStimulus(1'b0, 6, 0);
        checkOutput("glitch_busy_low", busy, 0);
        checkOutput("glitch_level", level, 0);

        // Bounce train: only the final stable run produces a set pulse.
        applyStimulus(1'b1, 1, 0);
        applyStimulus(1'b0, 1, 0);
        applyStimulus(1'b1, 1, 0);
        applyStimulus(1'b1, 1, 0);
        applyStimulus(1'b0, 1, 0);
        applyStimulus(1'b1, 5, 1);
        waitPulses(12);
        checkOutput("bounce_level", level, 1);

        // Back-to-back reversals spaced exactly p_stable cycles apart.
        applyStimulus(1'b0, p_stable, 2);
        applyStimulus(1'b1, p_stable, 1);
        applyStimulus(1'b0, 1, 2);
        waitPulses(16);
        checkOutput("b2b_level", level, 0);

        // Asynchronous reset in the middle of WAIT_HI abandons the candidate.
        applyStimulus(1'b1, 4, 0);
        checkOutput("midwait_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        raw_in  = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_level", level, 0);
        checkOutput("async_s", s, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("after_reset_level", level, 0);

        // p_stable=1 instance driving the SR latch model.
        for (int k = 0; k < 3; k++) begin
            logic v;
            v = (k == 1) ? 1'b0 : 1'b1;
            raw_in1 = v;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                checkOutput("latch_vs_level", q1, level1);
            end
            checkOutput("chain_level", level1, v);
            checkOutput("chain_latch", q1, v);
        end

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
